// File: rtl/lmn74194_deser.sv
// ---------------------------------------------------------------------------
// lmn74194_deser
//
// Serial-to-parallel capture block. Rebuilds N-bit words from a one-bit
// stream shifted in from either end, using the 74194 orientation:
//    dir=0 : feed from left  (bit enters at MSB, shifts toward LSB)
//    dir=1 : feed from right (bit enters at LSB, shifts toward MSB)
// A completed word is held in Q with a valid/ready handshake. When a word
// completes while the previous one is still unconsumed, the newest word
// replaces it (overrun).
//
// Optional feature macro: LMN_DESER_OVR_EN
//    defined   : ovr is a sticky overrun flag, cleared by ovr_clr or rst
//                (a simultaneous overrun wins over ovr_clr).
//    undefined : no overrun flag logic; ovr is tied to 0, ovr_clr ignored.
//
// Ports
//    mclk      in   main clock, all state changes on the rising edge
//    rst       in   asynchronous active-high reset
//    cen       in   clock enable for the bit-sampling path only
//    sin       in   serial data bit
//    sin_valid in   sin carries a bit this cen cycle
//    dir       in   shift orientation for the bit being sampled
//    start     in   word alignment, discards the partial word
//    Q         out  last completed word
//    q_valid   out  Q holds an unconsumed word
//    q_ready   in   consumer accepts Q
//    ovr       out  sticky overrun flag
//    ovr_clr   in   clears ovr
// ---------------------------------------------------------------------------
module lmn74194_deser #(
   parameter int N = 4
) (
   input  logic         mclk,
   input  logic         rst,
   input  logic         cen,
   input  logic         sin,
   input  logic         sin_valid,
   input  logic         dir,
   input  logic         start,
   output logic [N-1:0] Q,
   output logic         q_valid,
   input  logic         q_ready,
   output logic         ovr,
   input  logic         ovr_clr
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [N-1:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  word_q, word_d;
   logic          q_valid_q, q_valid_d;

   logic          sample_s;
   logic          align_s;
   logic          complete_s;
   logic          xfer_s;
   logic          overrun_s;
   logic [N-1:0]  shifted_s;

   // Shift one bit into a word in the requested 74194 orientation.
   function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur,
                                             input logic         b,
                                             input logic         d);
      logic [N-1:0] res;
      if (d) begin
         res = {cur[N-2:0], b};
      end else begin
         res = {b, cur[N-1:1]};
      end
      return res;
   endfunction

   assign sample_s  = cen & sin_valid;
   assign align_s   = cen & start;
   assign shifted_s = shift_in(sr_q, sin, dir);
   // start takes priority: the bit sampled with it begins a fresh word,
   // so it can never be the completing bit (N >= 2).
   assign complete_s = sample_s & ~align_s & (cnt_q == CNT_LAST);
   // Handshake is evaluated every mclk edge, independent of cen.
   assign xfer_s     = q_valid_q & q_ready;
   assign overrun_s  = complete_s & q_valid_q & ~q_ready;

   // Next-state for the shift register, bit counter, holding register and valid.
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      q_valid_d = q_valid_q;

      if (align_s) begin
         if (sin_valid) begin
            sr_d  = shift_in({N{1'b0}}, sin, dir);
            cnt_d = CNT_ONE;
         end else begin
            sr_d  = {N{1'b0}};
            cnt_d = {CW{1'b0}};
         end
      end else if (sample_s) begin
         sr_d = shifted_s;
         if (cnt_q == CNT_LAST) begin
            cnt_d = {CW{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         sr_d  = sr_q;
         cnt_d = cnt_q;
      end

      // Newest word always wins; completion keeps valid high even on transfer.
      if (complete_s) begin
         word_d    = shifted_s;
         q_valid_d = 1'b1;
      end else if (xfer_s) begin
         q_valid_d = 1'b0;
      end else begin
         q_valid_d = q_valid_q;
      end
   end

   // Datapath and handshake state registers.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         sr_q      <= {N{1'b0}};
         cnt_q     <= {CW{1'b0}};
         word_q    <= {N{1'b0}};
         q_valid_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         q_valid_q <= q_valid_d;
      end
   end

   assign Q       = word_q;
   assign q_valid = q_valid_q;

`ifdef LMN_DESER_OVR_EN
   logic ovr_q, ovr_d;

   // Sticky overrun flag; a new overrun beats a same-cycle clear.
   always_comb begin
      ovr_d = ovr_q;
      if (overrun_s) begin
         ovr_d = 1'b1;
      end else if (ovr_clr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Overrun flag register.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         ovr_q <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign ovr = ovr_q;
`else
   logic unused_ovr_s;
   assign unused_ovr_s = ovr_clr ^ overrun_s;
   assign ovr = 1'b0;
`endif

endmodule

// File: doc/lmn74194_deser.md
# lmn74194_deser

Serial-to-parallel capture block: the receiving end of the universal shift-register serializers used in the video and sound paths. It rebuilds N-bit words from a one-bit stream shifted in from either end, using the same shift orientation as the 74194 modes (feed from left / feed from right). Completed words are presented in a holding register with a valid/ready handshake, and optional overrun detection is available.

## Interface
- N, 4: word width in bits; N >= 2.

- mclk  in  1  main clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cen  in  1  clock enable; gates the bit-sampling path only.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin carries a bit this cen cycle.
- dir  in  1  0 = feed from left (enter at MSB, shift toward LSB); 1 = feed from right (enter at LSB, shift toward MSB).
- start  in  1  word alignment; discards the partial word.
- Q  out  N  holding register, last completed word.
- q_valid  out  1  Q holds an unconsumed word.
- q_ready  in  1  consumer accepts Q.
- ovr  out  1  sticky overrun flag (see Configuration).
- ovr_clr  in  1  clears ovr.

## Operation
- Internal state:
  - shift register sr[N-1:0].
  - bit counter cnt, $clog2(N) bits, range 0..N-1.
- Bit sample: a bit is sampled when cen && sin_valid.
  - dir=0: sr <= {sin, sr[N-1:1]}.
  - dir=1: sr <= {sr[N-2:0], sin}.
  - cnt increments.
- Word completion: a sample taken with cnt==N-1.
  - Q <= the shifted value, including the current bit.
  - q_valid <= 1.
  - cnt <= 0.
  - sr value after completion is don't-care; the next word fully overwrites it.
- start, when cen && start:
  - cnt <= 0 and sr <= 0.
  - If sin_valid is also high, the bit is the first bit of a new word: sr holds that one bit and cnt <= 1.
  - start does not affect Q, q_valid or ovr.
- dir may change between bits. The new direction applies to the next sampled bit; there is no realignment.
- Handshake:
  - Evaluated on every mclk edge and not gated by cen.
  - Transfer occurs when q_valid && q_ready.
  - On transfer, q_valid <= 0 unless a word completes in the same cycle.
  - q_ready with q_valid low has no effect.
- Simultaneous events:
  - Completion and transfer in the same cycle: Q <= new word, q_valid stays 1, no overrun.
  - Completion while q_valid=1 and no transfer: overrun. Q <= new word (the newest word always wins) and q_valid stays 1.
- Reset (asynchronous, takes effect immediately, including mid-word): sr=0, cnt=0, Q=0, q_valid=0, ovr=0.

## Timing
- Latency: Q and q_valid update on the same mclk edge that samples the last bit of a word. They are visible in the following cycle.
- Throughput: one bit per cen cycle. One word per N sampled bits.
- A consumer asserting q_ready continuously drains every word with zero stalls.
- q_valid is held for as many mclk cycles as q_ready stays low.
- ovr_clr and an overrun in the same cycle: ovr ends at 1 (set wins).

## Configuration
- LMN_DESER_OVR_EN defined:
  - ovr sets on any overrun and stays set until ovr_clr or rst.
- LMN_DESER_OVR_EN undefined:
  - Overrun logic is not built.
  - ovr is tied to 0 and ovr_clr is ignored.
  - Overrun data behaviour is unchanged: Q is overwritten.

## Test plan
- N=4, dir=0, bits 1,0,1,1 with cen=1, q_ready=0 -> after the 4th edge Q=4'hD, q_valid=1. Same bits with dir=1 -> Q=4'hB.
- sin_valid=1 with cen=0 for 10 cycles, then 4 valid bits 0,0,0,1 with dir=1 -> only 4 samples counted, Q=4'h1.
- Feed 2 bits, then start with sin_valid=1 and sin=1, then 3 more bits 0,0,0 with dir=1 -> Q=4'h8. The earlier 2 bits are discarded.
- q_ready held low while two words 4'hA then 4'h5 complete -> Q=4'h5, q_valid=1. ovr=1 with the macro, ovr=0 without. ovr_clr pulse -> ovr=0.
- q_ready held high and a continuous stream of 3 words -> q_valid is a 1-cycle pulse per word, each word seen exactly once. Completion coinciding with a pending transfer keeps q_valid=1 and ovr=0.
- Assert rst asynchronously between edges after 2 bits with q_valid=1 -> Q=0, q_valid=0, ovr=0 before the next mclk edge. After release, the next 4 bits form a complete word.
